sdram_cmd_responder: RTL and testbench

- Cycle-accurate SDR SDRAM device-side responder for the DSTB1 SDRAM path.
- Decodes RAS/CAS/RAMWE/BA/MA/DQM from the memory controller, enforces the power-up sequence, and tracks open rows per bank.
- Stores write data in a small on-chip array and returns read data after the programmed CAS latency.
- Serves as the bench partner for the SDRAM controller and as a protocol checker in system simulation.

---
 rtl/sdram_pkg.sv | 42 ++++
 rtl/sdram_read_pipe.sv | 47 ++++
 rtl/sdram_cmd_responder.sv | 246 ++++++++++++++++++++++++
 tb/tb_sdram_cmd_responder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdram_pkg
// Brief    : Shared command codes, init states, error bits and timing limits.
// Revision : 1.0 - initial release
// ============================================================================
package sdram_pkg;

    typedef enum logic [2:0] {
        CMD_LOADMODE  = 3'b000,
        CMD_REFRESH   = 3'b001,
        CMD_PRECHARGE = 3'b010,
        CMD_ACTIVE    = 3'b011,
        CMD_WRITE     = 3'b100,
        CMD_READ      = 3'b101,
        CMD_BST       = 3'b110,
        CMD_NOP       = 3'b111
    } cmd_t;

    typedef enum logic [1:0] {
        I_PRE  = 2'd0,
        I_REF  = 2'd1,
        I_DONE = 2'd2
    } init_state_t;

    localparam int ERR_INIT   = 0;
    localparam int ERR_BANK   = 1;
    localparam int ERR_MODE   = 2;
    localparam int ERR_TIMING = 3;

    localparam int T_RCD = 2;
    localparam int T_RP  = 2;
    localparam int T_RFC = 4;
    localparam int T_MRD = 2;

    // mode = {CAS latency[2:0], burst length[2:0]}; only CL2/CL3 with BL1 are modelled
    function automatic logic mode_ok(input logic [5:0] mode);
        return ((mode[5:3] == 3'd2) || (mode[5:3] == 3'd3)) && (mode[2:0] == 3'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_read_pipe.sv
`default_nettype none
// ============================================================================
// Module   : sdram_read_pipe
// Brief    : CAS-latency selectable read data/valid pipeline with output register.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_read_pipe #(
    parameter int DATA_W = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [1:0]        cl,
    input  logic              launch,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dq_out,
    output logic              dq_oe
);

    logic [DATA_W-1:0] r_dat [3];
    logic [2:0]        r_vld;
    logic              w_in_cl2;
    logic              w_in_cl3;

    // Entry slot is chosen so the output register fires exactly cl edges after launch
    assign w_in_cl3 = launch && (cl == 2'd3);
    assign w_in_cl2 = launch && (cl == 2'd2);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_vld  <= '0;
            r_dat  <= '{default: '0};
            dq_out <= '0;
            dq_oe  <= 1'b0;
        end else begin
            r_vld[0] <= w_in_cl3;
            r_dat[0] <= din;
            r_vld[1] <= r_vld[0] | w_in_cl2;
            r_dat[1] <= w_in_cl2 ? din : r_dat[0];
            r_vld[2] <= r_vld[1];
            r_dat[2] <= r_dat[1];
            dq_oe    <= r_vld[2];
            dq_out   <= r_vld[2] ? r_dat[2] : '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdram_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module   : sdram_cmd_responder
// Brief    : Device-side SDR SDRAM model: init checking, bank tracking, storage.
//            Define SDRAM_TIMING_CHECK_EN to build tRCD/tRP/tRFC/tMRD checks.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_cmd_responder
    import sdram_pkg::*;
#(
    parameter int ROW_BITS = 2,
    parameter int REF_MIN  = 2,
    parameter int DATA_W   = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                RAS,
    input  logic                CAS,
    input  logic                RAMWE,
    input  logic [1:0]          BA,
    input  logic [12:0]         MA,
    input  logic [DATA_W/8-1:0] DQM,
    input  logic [DATA_W-1:0]   DQ_IN,
    output logic [DATA_W-1:0]   DQ_OUT,
    output logic                DQ_OE,
    output logic                INIT_DONE,
    output logic [3:0]          ROW_OPEN,
    output logic [15:0]         REF_CNT,
    output logic [3:0]          ERR
);

    localparam int c_idx_w  = 2 + ROW_BITS + 8;
    localparam int c_depth  = 1 << c_idx_w;
    localparam int c_nbytes = DATA_W / 8;
    localparam int c_rc_w   = $clog2(REF_MIN + 1) + 1;
    localparam logic [c_rc_w-1:0] c_ref_min = c_rc_w'(REF_MIN);

    cmd_t                 w_cmd;
    init_state_t          r_init;
    init_state_t          w_init_nxt;
    logic [c_rc_w-1:0]    r_ref_init;
    logic [c_rc_w-1:0]    w_ref_init_nxt;
    logic [1:0]           r_cl;
    logic [1:0]           w_cl_nxt;
    logic [3:0]           r_open;
    logic [3:0]           w_open_nxt;
    logic [ROW_BITS-1:0]  r_row [4];
    logic [2:0]           r_err;
    logic [2:0]           w_err_set;
    logic [15:0]          r_ref_cnt;
    logic                 w_act_en;
    logic                 w_wr_en;
    logic                 w_rd_en;
    logic                 w_mode_ok;
    logic [c_idx_w-1:0]   w_idx;
    logic [DATA_W-1:0]    r_mem [c_depth];
    logic [DATA_W-1:0]    w_rd_data;
    logic                 w_unused;

    assign w_cmd     = cmd_t'({RAS, CAS, RAMWE});
    assign w_mode_ok = mode_ok({MA[6:4], MA[2:0]});
    assign w_idx     = {BA, r_row[BA], MA[7:0]};
    assign w_unused  = &{1'b0, MA[12:11], MA[9:8]};

    // Command decode: next init state, bank state and error events
    always_comb begin
        w_init_nxt     = r_init;
        w_ref_init_nxt = r_ref_init;
        w_cl_nxt       = r_cl;
        w_open_nxt     = r_open;
        w_err_set      = '0;
        w_act_en       = 1'b0;
        w_wr_en        = 1'b0;
        w_rd_en        = 1'b0;
        case (w_cmd)
            CMD_LOADMODE: begin
                if (r_init == I_DONE) begin
                    if (|r_open)        w_err_set[ERR_BANK] = 1'b1;
                    else if (w_mode_ok) w_cl_nxt = MA[5:4];
                    else                w_err_set[ERR_MODE] = 1'b1;
                end else begin
                    if ((r_init != I_REF) || (r_ref_init < c_ref_min))
                        w_err_set[ERR_INIT] = 1'b1;
                    if (!w_mode_ok)
                        w_err_set[ERR_MODE] = 1'b1;
                    if ((r_init == I_REF) && (r_ref_init >= c_ref_min) && w_mode_ok) begin
                        w_init_nxt = I_DONE;
                        w_cl_nxt   = MA[5:4];
                    end
                end
            end
            CMD_REFRESH: begin
                if (|r_open)
                    w_err_set[ERR_BANK] = 1'b1;
                if ((r_init == I_REF) && (r_ref_init < c_ref_min))
                    w_ref_init_nxt = r_ref_init + c_rc_w'(1);
            end
            CMD_PRECHARGE: begin
                if (MA[10]) w_open_nxt = '0;
                else        w_open_nxt[BA] = 1'b0;
                if ((r_init == I_PRE) && MA[10])
                    w_init_nxt = I_REF;
            end
            CMD_ACTIVE: begin
                if (r_init != I_DONE)  w_err_set[ERR_INIT] = 1'b1;
                else if (r_open[BA])   w_err_set[ERR_BANK] = 1'b1;
                else begin
                    w_open_nxt[BA] = 1'b1;
                    w_act_en       = 1'b1;
                end
            end
            CMD_WRITE, CMD_READ: begin
                if (r_init != I_DONE)  w_err_set[ERR_INIT] = 1'b1;
                else if (!r_open[BA])  w_err_set[ERR_BANK] = 1'b1;
                else begin
                    w_wr_en = (w_cmd == CMD_WRITE);
                    w_rd_en = (w_cmd == CMD_READ);
                    if (MA[10]) w_open_nxt[BA] = 1'b0;
                end
            end
            CMD_BST: w_err_set[ERR_BANK] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_init     <= I_PRE;
            r_ref_init <= '0;
            r_cl       <= 2'd2;
            r_open     <= '0;
            r_err      <= '0;
            r_ref_cnt  <= '0;
            r_row      <= '{default: '0};
        end else begin
            r_init     <= w_init_nxt;
            r_ref_init <= w_ref_init_nxt;
            r_cl       <= w_cl_nxt;
            r_open     <= w_open_nxt;
            r_err      <= r_err | w_err_set;
            if (w_cmd == CMD_REFRESH)
                r_ref_cnt <= r_ref_cnt + 16'd1;
            if (w_act_en)
                r_row[BA] <= MA[ROW_BITS-1:0];
        end
    end

    // Storage is deliberately left unreset so contents survive a controller reset
    always_ff @(posedge CLK) begin
        if (w_wr_en) begin
            for (int b = 0; b < c_nbytes; b++) begin
                if (!DQM[b])
                    r_mem[w_idx][b*8 +: 8] <= DQ_IN[b*8 +: 8];
            end
        end
    end

    always_comb begin
        w_rd_data = r_mem[w_idx];
        for (int b = 0; b < c_nbytes; b++) begin
            if (DQM[b])
                w_rd_data[b*8 +: 8] = '0;
        end
    end

    sdram_read_pipe #(
        .DATA_W (DATA_W)
    ) u_read_pipe (
        .CLK    (CLK),
        .RST    (RST),
        .cl     (r_cl),
        .launch (w_rd_en),
        .din    (w_rd_data),
        .dq_out (DQ_OUT),
        .dq_oe  (DQ_OE)
    );

    assign INIT_DONE = (r_init == I_DONE);
    assign ROW_OPEN  = r_open;
    assign REF_CNT   = r_ref_cnt;

`ifdef SDRAM_TIMING_CHECK_EN
    localparam logic [2:0] c_rcd = 3'(T_RCD - 1);
    localparam logic [2:0] c_rp  = 3'(T_RP - 1);
    localparam logic [2:0] c_rfc = 3'(T_RFC - 1);
    localparam logic [2:0] c_mrd = 3'(T_MRD - 1);

    logic [2:0] r_rcd_cnt [4];
    logic [2:0] r_rp_cnt  [4];
    logic [2:0] r_rfc_cnt;
    logic [2:0] r_mrd_cnt;
    logic       r_err_tim;
    logic       w_real_cmd;
    logic       w_viol;

    // Counters hold the clocks still to elapse before the guarded command is legal
    always_comb begin
        w_real_cmd = (w_cmd != CMD_NOP) && (w_cmd != CMD_BST);
        w_viol     = 1'b0;
        if (w_real_cmd && ((r_rfc_cnt != '0) || (r_mrd_cnt != '0)))
            w_viol = 1'b1;
        if (((w_cmd == CMD_READ) || (w_cmd == CMD_WRITE)) && (r_rcd_cnt[BA] != '0))
            w_viol = 1'b1;
        if ((w_cmd == CMD_ACTIVE) && (r_rp_cnt[BA] != '0))
            w_viol = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_rcd_cnt <= '{default: '0};
            r_rp_cnt  <= '{default: '0};
            r_rfc_cnt <= '0;
            r_mrd_cnt <= '0;
            r_err_tim <= 1'b0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (r_rcd_cnt[b] != '0) r_rcd_cnt[b] <= r_rcd_cnt[b] - 3'd1;
                if (r_rp_cnt[b] != '0)  r_rp_cnt[b]  <= r_rp_cnt[b] - 3'd1;
            end
            if (r_rfc_cnt != '0) r_rfc_cnt <= r_rfc_cnt - 3'd1;
            if (r_mrd_cnt != '0) r_mrd_cnt <= r_mrd_cnt - 3'd1;
            case (w_cmd)
                CMD_ACTIVE:    r_rcd_cnt[BA] <= c_rcd;
                CMD_PRECHARGE: begin
                    if (MA[10]) r_rp_cnt <= '{default: c_rp};
                    else        r_rp_cnt[BA] <= c_rp;
                end
                CMD_READ, CMD_WRITE: begin
                    if (MA[10]) r_rp_cnt[BA] <= c_rp;
                end
                CMD_REFRESH:   r_rfc_cnt <= c_rfc;
                CMD_LOADMODE:  r_mrd_cnt <= c_mrd;
                default: ;
            endcase
            if (w_viol)
                r_err_tim <= 1'b1;
        end
    end

    assign ERR = {r_err_tim, r_err};
`else
    assign ERR = {1'b0, r_err};
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdram_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_cmd_responder
// Brief    : Scoreboard bench for sdram_cmd_responder (CL latency, masks, errors).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_cmd_responder;
    import sdram_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        RAS = 1'b1, CAS = 1'b1, RAMWE = 1'b1;
    logic [1:0]  BA = '0;
    logic [12:0] MA = '0;
    logic [1:0]  DQM = '0;
    logic [15:0] DQ_IN = '0;
    logic [15:0] DQ_OUT;
    logic        DQ_OE;
    logic        INIT_DONE;
    logic [3:0]  ROW_OPEN;
    logic [15:0] REF_CNT;
    logic [3:0]  ERR;

    typedef struct {
        int          due;
        logic [15:0] data;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [15:0] model [int];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          tb_cl = 2;

    sdram_cmd_responder #(.ROW_BITS(2), .REF_MIN(2), .DATA_W(16)) dut (
        .CLK(CLK), .RST(RST), .RAS(RAS), .CAS(CAS), .RAMWE(RAMWE), .BA(BA), .MA(MA),
        .DQM(DQM), .DQ_IN(DQ_IN), .DQ_OUT(DQ_OUT), .DQ_OE(DQ_OE), .INIT_DONE(INIT_DONE),
        .ROW_OPEN(ROW_OPEN), .REF_CNT(REF_CNT), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    // Read-data monitor: every DQ_OE cycle must match the oldest expected read
    initial forever begin
        @(negedge CLK);
        if (RST) begin
            if (DQ_OE) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_read: DQ_OE=1 DQ_OUT=%h at cycle %0d, required DQ_OE=0", DQ_OUT, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    if (DQ_OUT !== mon_e.data || cyc != mon_e.due) begin
                        n_fail++;
                        $display("FAIL read_data: got %h at cycle %0d, required %h at cycle %0d",
                                 DQ_OUT, cyc, mon_e.data, mon_e.due);
                    end
                end
            end else if (sb.size() != 0 && sb[0].due <= cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL read_missing: DQ_OE=0 at cycle %0d, required data %h", cyc, sb[0].data);
                void'(sb.pop_front());
            end
        end
    end

    task automatic issue(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] ma,
                         input logic [1:0] dqm, input logic [15:0] d);
        @(negedge CLK);
        {RAS, CAS, RAMWE} = c;
        BA = ba; MA = ma; DQM = dqm; DQ_IN = d;
    endtask

    task automatic nops(input int n);
        repeat (n) begin
            @(negedge CLK);
            {RAS, CAS, RAMWE} = CMD_NOP;
            DQM = '0;
        end
    endtask

    task automatic do_write(input logic [1:0] ba, input logic [1:0] row, input logic [7:0] col,
                            input logic [15:0] d, input logic [1:0] dqm, input logic ap);
        int          k;
        logic [15:0] v;
        k = int'({ba, row, col});
        v = model.exists(k) ? model[k] : 16'h0000;
        if (!dqm[0]) v[7:0]  = d[7:0];
        if (!dqm[1]) v[15:8] = d[15:8];
        model[k] = v;
        issue(CMD_WRITE, ba, {2'b00, ap, 2'b00, col}, dqm, d);
    endtask

    task automatic do_read(input logic [1:0] ba, input logic [1:0] row, input logic [7:0] col,
                           input logic [1:0] dqm, input logic ap, input bit expect_data);
        exp_t e;
        issue(CMD_READ, ba, {2'b00, ap, 2'b00, col}, dqm, 16'h0000);
        if (expect_data) begin
            e.data = model[int'({ba, row, col})];
            if (dqm[0]) e.data[7:0]  = 8'h00;
            if (dqm[1]) e.data[15:8] = 8'h00;
            e.due = cyc + 1 + tb_cl;
            sb.push_back(e);
        end
    endtask

    task automatic wait_drain();
        nops(1);
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge CLK);
    endtask

    task automatic watch_oe(input int n, output bit seen);
        seen = 1'b0;
        repeat (n) begin
            @(negedge CLK);
            if (DQ_OE) seen = 1'b1;
        end
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        RST = 1'b0;
        {RAS, CAS, RAMWE} = CMD_NOP;
        DQM = '0;
        sb.delete();
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        tb_cl = 2;
    endtask

    task automatic do_init();
        issue(CMD_PRECHARGE, 2'd0, 13'h0400, 2'b00, 16'h0); nops(4);
        issue(CMD_REFRESH,   2'd0, 13'h0000, 2'b00, 16'h0); nops(4);
        issue(CMD_REFRESH,   2'd0, 13'h0000, 2'b00, 16'h0); nops(4);
        issue(CMD_LOADMODE,  2'd0, 13'h0020, 2'b00, 16'h0); nops(4);
        tb_cl = 2;
    endtask

    task automatic test_reset();
        apply_reset();
        nops(1);
        n_checks++; if (DQ_OE !== 1'b0)      begin n_fail++; $display("FAIL reset_dq_oe: got %b, required 0", DQ_OE); end
        n_checks++; if (DQ_OUT !== 16'h0)    begin n_fail++; $display("FAIL reset_dq_out: got %h, required 0000", DQ_OUT); end
        n_checks++; if (INIT_DONE !== 1'b0)  begin n_fail++; $display("FAIL reset_init_done: got %b, required 0", INIT_DONE); end
        n_checks++; if (ROW_OPEN !== 4'h0)   begin n_fail++; $display("FAIL reset_row_open: got %h, required 0", ROW_OPEN); end
        n_checks++; if (REF_CNT !== 16'h0)   begin n_fail++; $display("FAIL reset_ref_cnt: got %h, required 0000", REF_CNT); end
        n_checks++; if (ERR !== 4'h0)        begin n_fail++; $display("FAIL reset_err: got %h, required 0", ERR); end
    endtask

    task automatic test_init();
        do_init();
        n_checks++; if (INIT_DONE !== 1'b1) begin n_fail++; $display("FAIL init_done: got %b, required 1", INIT_DONE); end
        n_checks++; if (ERR !== 4'h0)       begin n_fail++; $display("FAIL init_err: got %h, required 0", ERR); end
        n_checks++; if (REF_CNT !== 16'd2)  begin n_fail++; $display("FAIL init_ref_cnt: got %0d, required 2", REF_CNT); end
    endtask

    task automatic test_write_read();
        issue(CMD_ACTIVE, 2'd1, 13'h0003, 2'b00, 16'h0); nops(1);
        n_checks++; if (ROW_OPEN !== 4'b0010) begin n_fail++; $display("FAIL active_row_open: got %b, required 0010", ROW_OPEN); end
        do_write(2'd1, 2'd3, 8'h55, 16'hBEEF, 2'b00, 1'b0);
        do_read(2'd1, 2'd3, 8'h55, 2'b00, 1'b0, 1'b1);
        wait_drain();
        do_write(2'd1, 2'd3, 8'h56, 16'hCAFE, 2'b00, 1'b0);
        do_read(2'd1, 2'd3, 8'h55, 2'b00, 1'b0, 1'b1);
        do_read(2'd1, 2'd3, 8'h56, 2'b00, 1'b0, 1'b1);
        wait_drain();
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL back_to_back_drain: %0d outstanding, required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_byte_mask();
        do_write(2'd1, 2'd3, 8'h55, 16'h1234, 2'b10, 1'b0);
        do_read(2'd1, 2'd3, 8'h55, 2'b00, 1'b0, 1'b1);
        do_read(2'd1, 2'd3, 8'h56, 2'b01, 1'b0, 1'b1);
        wait_drain();
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL mask_drain: %0d outstanding, required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_cl3();
        issue(CMD_PRECHARGE, 2'd0, 13'h0400, 2'b00, 16'h0); nops(4);
        issue(CMD_LOADMODE,  2'd0, 13'h0030, 2'b00, 16'h0); nops(4);
        tb_cl = 3;
        issue(CMD_LOADMODE,  2'd0, 13'h0023, 2'b00, 16'h0); nops(4);
        n_checks++; if (ERR[2] !== 1'b1)   begin n_fail++; $display("FAIL bad_mode_err2: got %b, required 1", ERR[2]); end
        n_checks++; if (ERR[1:0] !== 2'b0) begin n_fail++; $display("FAIL mode_err10: got %b, required 00", ERR[1:0]); end
        issue(CMD_ACTIVE, 2'd1, 13'h0003, 2'b00, 16'h0); nops(1);
        do_read(2'd1, 2'd3, 8'h55, 2'b00, 1'b0, 1'b1);
        wait_drain();
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL cl3_drain: %0d outstanding, required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_autoprecharge();
        bit seen;
        do_write(2'd1, 2'd3, 8'h57, 16'h0F0F, 2'b00, 1'b1);
        nops(1);
        n_checks++; if (ROW_OPEN !== 4'h0) begin n_fail++; $display("FAIL autopre_row_open: got %b, required 0000", ROW_OPEN); end
        n_checks++; if (ERR[1] !== 1'b0)   begin n_fail++; $display("FAIL autopre_err1_before: got %b, required 0", ERR[1]); end
        do_read(2'd1, 2'd3, 8'h57, 2'b00, 1'b0, 1'b0);
        nops(1);
        watch_oe(6, seen);
        n_checks++; if (seen !== 1'b0)   begin n_fail++; $display("FAIL closed_read_oe: got %b, required 0", seen); end
        n_checks++; if (ERR[1] !== 1'b1) begin n_fail++; $display("FAIL closed_read_err1: got %b, required 1", ERR[1]); end
    endtask

    task automatic test_mid_reset();
        bit seen;
        nops(2);
        issue(CMD_ACTIVE, 2'd1, 13'h0003, 2'b00, 16'h0); nops(1);
        do_read(2'd1, 2'd3, 8'h55, 2'b00, 1'b0, 1'b0);
        apply_reset();
        watch_oe(6, seen);
        n_checks++; if (seen !== 1'b0)      begin n_fail++; $display("FAIL mid_reset_oe: got %b, required 0", seen); end
        n_checks++; if (ROW_OPEN !== 4'h0)  begin n_fail++; $display("FAIL mid_reset_row_open: got %b, required 0000", ROW_OPEN); end
        n_checks++; if (INIT_DONE !== 1'b0) begin n_fail++; $display("FAIL mid_reset_init: got %b, required 0", INIT_DONE); end
        n_checks++; if (ERR !== 4'h0)       begin n_fail++; $display("FAIL mid_reset_err: got %h, required 0", ERR); end
    endtask

    task automatic test_init_errors();
        issue(CMD_ACTIVE, 2'd0, 13'h0001, 2'b00, 16'h0); nops(4);
        n_checks++; if (ERR[0] !== 1'b1)   begin n_fail++; $display("FAIL early_active_err0: got %b, required 1", ERR[0]); end
        n_checks++; if (ROW_OPEN !== 4'h0) begin n_fail++; $display("FAIL early_active_row_open: got %b, required 0000", ROW_OPEN); end
        issue(CMD_PRECHARGE, 2'd0, 13'h0400, 2'b00, 16'h0); nops(4);
        issue(CMD_REFRESH,   2'd0, 13'h0000, 2'b00, 16'h0); nops(4);
        issue(CMD_LOADMODE,  2'd0, 13'h0020, 2'b00, 16'h0); nops(4);
        n_checks++; if (INIT_DONE !== 1'b0) begin n_fail++; $display("FAIL short_refresh_init: got %b, required 0", INIT_DONE); end
        issue(CMD_REFRESH,   2'd0, 13'h0000, 2'b00, 16'h0); nops(4);
        issue(CMD_LOADMODE,  2'd0, 13'h0023, 2'b00, 16'h0); nops(4);
        n_checks++; if (ERR[2] !== 1'b1)    begin n_fail++; $display("FAIL init_bl8_err2: got %b, required 1", ERR[2]); end
        n_checks++; if (INIT_DONE !== 1'b0) begin n_fail++; $display("FAIL init_bl8_done: got %b, required 0", INIT_DONE); end
        issue(CMD_LOADMODE,  2'd0, 13'h0020, 2'b00, 16'h0); nops(4);
        n_checks++; if (INIT_DONE !== 1'b1) begin n_fail++; $display("FAIL late_init_done: got %b, required 1", INIT_DONE); end
        n_checks++; if (REF_CNT !== 16'd2)  begin n_fail++; $display("FAIL late_init_ref_cnt: got %0d, required 2", REF_CNT); end
    endtask

    task automatic test_timing();
        logic exp_err3;
`ifdef SDRAM_TIMING_CHECK_EN
        exp_err3 = 1'b1;
`else
        exp_err3 = 1'b0;
`endif
        apply_reset();
        do_init();
        n_checks++; if (ERR !== 4'h0) begin n_fail++; $display("FAIL timing_pre_err: got %h, required 0", ERR); end
        issue(CMD_ACTIVE, 2'd1, 13'h0003, 2'b00, 16'h0);
        do_read(2'd1, 2'd3, 8'h55, 2'b00, 1'b0, 1'b1);
        wait_drain();
        n_checks++; if (sb.size() != 0)    begin n_fail++; $display("FAIL timing_read_drain: %0d outstanding, required 0", sb.size()); sb.delete(); end
        n_checks++; if (ERR[3] !== exp_err3) begin n_fail++; $display("FAIL trcd_err3: got %b, required %b", ERR[3], exp_err3); end
    endtask

    initial begin
        test_reset();
        test_init();
        test_write_read();
        test_byte_mask();
        test_cl3();
        test_autoprecharge();
        test_mid_reset();
        test_init_errors();
        test_timing();
        nops(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
